// File: rtl/sobel_pkg.sv
// sobel_pkg: shared widths and constants for the 3x3 Sobel edge block.
//   PIX_W    - video pixel width
//   SUM_W    - width of one weighted partial sum (max 4*255 = 1020)
//   MAG_W    - width of |Gx| + |Gy| (max 2040)
//   CNT_W    - width of the column/row position counters
//   PIPE_LAT - window-in to pixel-out latency in clocks
//   SAT_VAL  - saturation / binary-high pixel value
package sobel_pkg;

    localparam int PIX_W    = 8;
    localparam int SUM_W    = 10;
    localparam int MAG_W    = 11;
    localparam int CNT_W    = 11;
    localparam int PIPE_LAT = 3;

    localparam logic [PIX_W-1:0] SAT_VAL = 8'd255;

    // a + 2*b + c on one kernel row/column, zero-extended (no signed math).
    function automatic logic [SUM_W-1:0] wsum(input logic [PIX_W-1:0] a,
                                              input logic [PIX_W-1:0] b,
                                              input logic [PIX_W-1:0] c);
        return SUM_W'(a) + (SUM_W'(b) << 1) + SUM_W'(c);
    endfunction

    // Magnitude of a difference of two unsigned sums: larger minus smaller.
    function automatic logic [SUM_W-1:0] abs_diff(input logic [SUM_W-1:0] a,
                                                  input logic [SUM_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/sobel_pos_ctrl.sv
// sobel_pos_ctrl: tracks the column/row of the current window centre and
// flags windows that sit on the image border.
// Ports:
//   video_clk  in   pixel clock
//   rst        in   asynchronous active-high reset
//   matrix_de  in   window valid
//   matrix_vs  in   frame sync; rising edge restarts position at (0,0)
//   border     out  current window centre is in row/col 0 or the last row/col
module sobel_pos_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 1920,
    parameter int IMG_HEIGHT = 1080
) (
    input  logic video_clk,
    input  logic rst,
    input  logic matrix_de,
    input  logic matrix_vs,
    output logic border
);

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_WIDTH - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_HEIGHT - 1);

    logic [CNT_W-1:0] col_cnt;
    logic [CNT_W-1:0] row_cnt;
    logic             vs_d;
    logic             vs_rise;

    assign vs_rise = matrix_vs & ~vs_d;

    // The pixel presented in a cycle uses the counter values before that
    // cycle's update; a vs rising edge wins over any increment.
    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
            vs_d    <= 1'b0;
        end else begin
            vs_d <= matrix_vs;
            if (vs_rise) begin
                col_cnt <= '0;
                row_cnt <= '0;
            end else if (matrix_de) begin
                if (col_cnt == COL_LAST) begin
                    col_cnt <= '0;
                    row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end
        end
    end

    assign border = (col_cnt == '0) || (col_cnt == COL_LAST) ||
                    (row_cnt == '0) || (row_cnt == ROW_LAST);

endmodule

// File: rtl/sobel_edge_3x3.sv
// sobel_edge_3x3: reduces each 3x3 window to a Sobel gradient magnitude
// (saturated to 8 bits) or a thresholded binary edge, with DE/VS realigned.
// Ports:
//   video_clk            in   pixel clock
//   rst                  in   asynchronous active-high reset
//   matrix_de/matrix_vs  in   window valid / frame sync
//   matrix11..matrix33   in   window pixels (row 1 oldest, column 3 newest)
//   thresh               in   binary threshold, used in the output stage
//   bin_mode             in   1: binary 0/255 output, 0: saturated magnitude
//   edge_de/edge_vs      out  matrix_de/matrix_vs delayed by PIPE_LAT
//   edge_data            out  output pixel, 0 whenever edge_de is 0
// Stream semantics: no backpressure. A window is transferred on every clock
// where matrix_de is 1; exactly PIPE_LAT clocks later edge_de is 1 with its
// result. Gaps in matrix_de pass through as gaps in edge_de.
module sobel_edge_3x3
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 1920,
    parameter int IMG_HEIGHT = 1080
) (
    input  logic             video_clk,
    input  logic             rst,
    input  logic             matrix_de,
    input  logic             matrix_vs,
    input  logic [PIX_W-1:0] matrix11,
    input  logic [PIX_W-1:0] matrix12,
    input  logic [PIX_W-1:0] matrix13,
    input  logic [PIX_W-1:0] matrix21,
    input  logic [PIX_W-1:0] matrix22,
    input  logic [PIX_W-1:0] matrix23,
    input  logic [PIX_W-1:0] matrix31,
    input  logic [PIX_W-1:0] matrix32,
    input  logic [PIX_W-1:0] matrix33,
    input  logic [PIX_W-1:0] thresh,
    input  logic             bin_mode,
    output logic             edge_de,
    output logic             edge_vs,
    output logic [PIX_W-1:0] edge_data
);

    logic                border_now;
    logic [SUM_W-1:0]    gx_p, gx_n, gy_p, gy_n;
    logic [SUM_W-1:0]    abs_gx, abs_gy;
    logic                bd_s1, bd_s2;
    logic [PIPE_LAT-1:0] de_sr, vs_sr;
    logic [MAG_W-1:0]    mag;
    logic [PIX_W-1:0]    sat;
    logic [PIX_W-1:0]    pix;

    // The Sobel kernel has a zero centre weight.
    logic unused_ok;
    assign unused_ok = &{1'b0, matrix22};

    sobel_pos_ctrl #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT)
    ) u_pos (
        .video_clk(video_clk),
        .rst      (rst),
        .matrix_de(matrix_de),
        .matrix_vs(matrix_vs),
        .border   (border_now)
    );

    // Stage 1: positive/negative partial sums and the border flag.
    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            gx_p  <= '0;
            gx_n  <= '0;
            gy_p  <= '0;
            gy_n  <= '0;
            bd_s1 <= 1'b0;
        end else begin
            gx_p  <= wsum(matrix13, matrix23, matrix33);
            gx_n  <= wsum(matrix11, matrix21, matrix31);
            gy_p  <= wsum(matrix31, matrix32, matrix33);
            gy_n  <= wsum(matrix11, matrix12, matrix13);
            bd_s1 <= border_now;
        end
    end

    // Stage 2: gradient magnitudes.
    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            abs_gx <= '0;
            abs_gy <= '0;
            bd_s2  <= 1'b0;
        end else begin
            abs_gx <= abs_diff(gx_p, gx_n);
            abs_gy <= abs_diff(gy_p, gy_n);
            bd_s2  <= bd_s1;
        end
    end

    // Stage 3 combinational: sum, saturate, optional threshold.
    always_comb begin
        mag = MAG_W'(abs_gx) + MAG_W'(abs_gy);
        sat = (mag > MAG_W'(SAT_VAL)) ? SAT_VAL : mag[PIX_W-1:0];
        pix = sat;
        if (bin_mode) begin
            pix = (sat >= thresh) ? SAT_VAL : '0;
        end
    end

    // Stage 3 register plus DE/VS delay lines; de_sr[PIPE_LAT-2] is the
    // valid bit travelling with the stage-2 data.
    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            de_sr     <= '0;
            vs_sr     <= '0;
            edge_data <= '0;
        end else begin
            de_sr     <= {de_sr[PIPE_LAT-2:0], matrix_de};
            vs_sr     <= {vs_sr[PIPE_LAT-2:0], matrix_vs};
            edge_data <= (de_sr[PIPE_LAT-2] && !bd_s2) ? pix : '0;
        end
    end

    assign edge_de = de_sr[PIPE_LAT-1];
    assign edge_vs = vs_sr[PIPE_LAT-1];

endmodule

// File: tb/tb_sobel_edge_3x3.sv
// Bench for sobel_edge_3x3 on an 8x4 image: directed frames with
// hand-computed pixel values, mid-line vs, async reset, then random traffic
// compared cycle by cycle against an arithmetic reference model.
module tb_sobel_edge_3x3;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int EW = 11;  // {de, vs, border, sat[7:0]}

    logic       video_clk = 1'b0;
    logic       rst;
    logic       matrix_de, matrix_vs;
    logic [7:0] m11, m12, m13, m21, m22, m23, m31, m32, m33;
    logic [7:0] thresh;
    logic       bin_mode;
    logic       edge_de, edge_vs;
    logic [7:0] edge_data;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [EW-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 video_clk = ~video_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog");
    end

    sobel_edge_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .video_clk(video_clk),
        .rst      (rst),
        .matrix_de(matrix_de),
        .matrix_vs(matrix_vs),
        .matrix11 (m11), .matrix12(m12), .matrix13(m13),
        .matrix21 (m21), .matrix22(m22), .matrix23(m23),
        .matrix31 (m31), .matrix32(m32), .matrix33(m33),
        .thresh   (thresh),
        .bin_mode (bin_mode),
        .edge_de  (edge_de),
        .edge_vs  (edge_vs),
        .edge_data(edge_data)
    );

    task automatic check(input string name, input int act, input int exp_v);
        tests_run++;
        if (act != exp_v) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         mcol = 0, mrow = 0;
    logic       mvs_prev = 1'b0;
    logic [7:0] thr_now = 8'd0;
    logic       bin_now = 1'b0;

    always @(posedge video_clk) begin
        int gx, gy, mag, sat;
        logic bd;
        // Mode inputs seen at this edge govern the pixel that leaves now.
        thr_now = thresh;
        bin_now = bin_mode;
        if (rst) begin
            exp_q.delete();
            exp_q.push_back('0);
            exp_q.push_back('0);
            mcol = 0;
            mrow = 0;
            mvs_prev = 1'b0;
        end else begin
            gx = (int'(m13) + 2 * int'(m23) + int'(m33)) - (int'(m11) + 2 * int'(m21) + int'(m31));
            gy = (int'(m31) + 2 * int'(m32) + int'(m33)) - (int'(m11) + 2 * int'(m12) + int'(m13));
            mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            sat = (mag > 255) ? 255 : mag;
            bd = (mcol == 0) || (mcol == W - 1) || (mrow == 0) || (mrow == H - 1);
            exp_q.push_back({matrix_de, matrix_vs, bd, 8'(sat)});
            if (matrix_vs && !mvs_prev) begin
                mcol = 0;
                mrow = 0;
            end else if (matrix_de) begin
                if (mcol == W - 1) begin
                    mcol = 0;
                    mrow = (mrow == H - 1) ? 0 : mrow + 1;
                end else begin
                    mcol = mcol + 1;
                end
            end
            mvs_prev = matrix_vs;
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge video_clk) begin
        logic [EW-1:0] e;
        int exp_data;
        if (rst) begin
            check("rst_edge_de", edge_de, 0);
            check("rst_edge_vs", edge_vs, 0);
            check("rst_edge_data", edge_data, 0);
        end else if (exp_q.size() >= 3) begin
            e = exp_q.pop_front();
            if (!e[10] || e[8]) exp_data = 0;
            else if (bin_now) exp_data = (e[7:0] >= thr_now) ? 255 : 0;
            else exp_data = e[7:0];
            check("model_edge_de", edge_de, e[10]);
            check("model_edge_vs", edge_vs, e[9]);
            check("model_edge_data", edge_data, exp_data);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic de, input logic vs);
        @(posedge video_clk);
        #1;
        matrix_de = de;
        matrix_vs = vs;
    endtask

    task automatic set_cols(input logic [7:0] lv, input logic [7:0] cv, input logic [7:0] rv);
        m11 = lv; m21 = lv; m31 = lv;
        m12 = cv; m22 = cv; m32 = cv;
        m13 = rv; m23 = rv; m33 = rv;
    endtask

    // Call right after the window is set; its pixel is visible 4 negedges on.
    task automatic expect_lit(input string name, input int exp_v);
        fork
            begin
                repeat (4) @(negedge video_clk);
                check({name, "_de"}, edge_de, 1);
                check(name, edge_data, exp_v);
            end
        join_none
    endtask

    task automatic run_frame(input logic [7:0] lv, input logic [7:0] cv,
                             input logic [7:0] rv, input int lit, input string name);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        for (int ri = 0; ri < H; ri++) begin
            for (int ci = 0; ci < W; ci++) begin
                step(1'b1, 1'b0);
                set_cols(lv, cv, rv);
                expect_lit($sformatf("%s_r%0dc%0d", name, ri, ci),
                           (ri == 0 || ri == H - 1 || ci == 0 || ci == W - 1) ? 0 : lit);
            end
            step(1'b0, 1'b0);
        end
        repeat (4) step(1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        matrix_de = 1'b0;
        matrix_vs = 1'b0;
        thresh = 8'd0;
        bin_mode = 1'b0;
        set_cols(8'd0, 8'd0, 8'd0);
        @(negedge video_clk);
        check("reset_edge_de", edge_de, 0);
        check("reset_edge_data", edge_data, 0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 1'b0);

        // Directed frames with hand-computed interior values.
        run_frame(8'd100, 8'd100, 8'd100, 0, "uniform");
        run_frame(8'd0, 8'd128, 8'd255, 255, "vertical");
        run_frame(8'd0, 8'd12, 8'd25, 100, "weak");
        bin_mode = 1'b1;
        thresh = 8'd128;
        run_frame(8'd0, 8'd12, 8'd25, 0, "weak_t128");
        thresh = 8'd100;
        run_frame(8'd0, 8'd12, 8'd25, 255, "weak_t100");
        bin_mode = 1'b0;

        // vs rising edge in the middle of row 1: next pixel is col 0 again.
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        for (int ci = 0; ci < W; ci++) begin
            step(1'b1, 1'b0);
            set_cols(8'd0, 8'd128, 8'd255);
        end
        for (int ci = 0; ci < 5; ci++) begin
            step(1'b1, 1'b0);
            set_cols(8'd0, 8'd128, 8'd255);
            expect_lit($sformatf("midvs_pre_c%0d", ci), (ci == 0) ? 0 : 255);
        end
        step(1'b0, 1'b1);
        for (int ci = 0; ci < 3; ci++) begin
            step(1'b1, 1'b0);
            set_cols(8'd0, 8'd128, 8'd255);
            expect_lit($sformatf("midvs_post_c%0d", ci), 0);
        end
        repeat (5) step(1'b0, 1'b0);

        // Asynchronous reset while edge_de is high.
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        for (int ci = 0; ci < 5; ci++) begin
            step(1'b1, 1'b0);
            set_cols(8'd0, 8'd128, 8'd255);
        end
        @(negedge video_clk);
        check("pre_rst_edge_de", edge_de, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_edge_de", edge_de, 0);
        check("async_rst_edge_vs", edge_vs, 0);
        check("async_rst_edge_data", edge_data, 0);
        matrix_de = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        set_cols(8'd0, 8'd128, 8'd255);
        expect_lit("post_rst_first", 0);
        repeat (5) step(1'b0, 1'b0);

        // Random traffic: bubbles, mid-line vs, changing threshold and mode.
        for (int n = 0; n < 1500; n++) begin
            int rng;
            step($urandom_range(0, 9) != 0, $urandom_range(0, 60) == 0);
            rng = ($urandom_range(0, 1) != 0) ? 255 : 30;
            m11 = 8'($urandom_range(0, rng)); m12 = 8'($urandom_range(0, rng));
            m13 = 8'($urandom_range(0, rng)); m21 = 8'($urandom_range(0, rng));
            m22 = 8'($urandom_range(0, rng)); m23 = 8'($urandom_range(0, rng));
            m31 = 8'($urandom_range(0, rng)); m32 = 8'($urandom_range(0, rng));
            m33 = 8'($urandom_range(0, rng));
            thresh = 8'($urandom_range(0, 255));
            bin_mode = 1'($urandom_range(0, 1));
        end
        repeat (6) step(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sobel_edge_3x3.md
# sobel_edge_3x3

Consumes the 3x3 pixel window stream produced by the line-buffer matrix generator and reduces each window to one output pixel, the Sobel gradient magnitude or a thresholded binary edge. The output is a single 8-bit video stream with realigned DE/VS. It sits directly downstream of the window generator and upstream of any video output/overlay stage.

## Interface
- IMG_WIDTH, 1920, active pixels per line; 11-bit range.
- IMG_HEIGHT, 1080, active lines per frame; 11-bit range.
- video_clk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- matrix_de  in  1  window valid; high for IMG_WIDTH consecutive cycles per line.
- matrix_vs  in  1  frame sync; rising edge marks frame start.
- matrix11..matrix33  in  8 each  window pixels; row 1 is oldest line, column 3 is newest pixel; matrix22 is centre.
- thresh  in  8  edge threshold; sampled every cycle in pipeline stage 3.
- bin_mode  in  1  1 selects binary output (0/255), 0 selects saturated magnitude.
- edge_de  out  1  output pixel valid.
- edge_vs  out  1  matrix_vs delayed to match edge_de.
- edge_data  out  8  output pixel.

## Operation
- Gx = (m13 + 2·m23 + m33) − (m11 + 2·m21 + m31). Gy = (m31 + 2·m32 + m33) − (m11 + 2·m12 + m13).
- Stage 1 registers the four partial sums (gx_p, gx_n, gy_p, gy_n), each 10 bits unsigned (max 1020).
- Stage 2 registers |Gx| = larger minus smaller of the pair, 10 bits, and |Gy| likewise. No signed arithmetic.
- Stage 3 computes mag = |Gx| + |Gy| as 11 bits (max 2040). sat = 255 if mag > 255, else mag[7:0].
  - bin_mode=1: edge_data = 255 if sat >= thresh, else 0.
  - bin_mode=0: edge_data = sat.
- Position tracking:
  - col_cnt (11 bit) increments on each matrix_de cycle and clears on the cycle after the last pixel of the line (col_cnt == IMG_WIDTH−1).
  - row_cnt (11 bit) increments when a line completes and wraps at IMG_HEIGHT−1.
  - A matrix_vs rising edge clears both counters, overriding any increment in the same cycle.
  - Counters hold while matrix_de is low mid-line.
- Border forcing: when the window centre is at col 0, col IMG_WIDTH−1, row 0 or row IMG_HEIGHT−1, edge_data is 0 regardless of mode. The border flag is computed at stage 1 and piped alongside the data.
- When edge_de=0, edge_data=0.

## Timing
- Latency is 3 cycles. edge_de(t+3) = matrix_de(t), and edge_vs(t+3) = matrix_vs(t). The window sampled at t appears on edge_data at t+3.
- No backpressure. One window in, one pixel out per cycle, sustained indefinitely.
- Reset: edge_de=0, edge_vs=0, edge_data=0, all pipeline registers, counters and flags 0. Any frame in flight is discarded.
- After reset release mid-frame, counters start at 0, so the border mask is wrong only until the next matrix_vs rising edge. This is accepted.
- Gaps in matrix_de propagate unchanged; bubbles stay bubbles at the output.
- A frame shorter than IMG_HEIGHT is truncated by the next vs edge without error.

## Structure
- Package sobel_pkg holds:
  - PIX_W=8, SUM_W=10, MAG_W=11;
  - PIPE_LAT=3;
  - the saturation constant 8'd255.
- Sub-module sobel_pos_ctrl: col/row counters, vs edge detect, border flag output. Keeps position logic testable separately from arithmetic.
- The top level holds the three arithmetic stages and the DE/VS/border delay lines.

## Test plan
- Uniform window, all pixels 100, bin_mode=0, interior position -> edge_data=0 exactly 3 cycles after matrix_de.
- Vertical edge, left column 0, right column 255, middle 128; bin_mode=0 -> Gx=1020, Gy=0, edge_data=255 (saturated).
- Weak edge, left column 0, right column 25, bin_mode=0 -> 100. Same with bin_mode=1, thresh=128 -> 0. thresh=100 -> 255.
- Full 8x4 frame (IMG_WIDTH=8, IMG_HEIGHT=4), all-edge content -> row 0, row 3, col 0 and col 7 outputs are 0; interior outputs are 255; edge_de pattern equals matrix_de shifted by 3.
- matrix_vs pulse mid-line at col 5 -> counters clear; the next pixel is treated as col 0 and forced to 0.
- rst asserted while edge_de=1 -> all outputs 0 on the same edge. After release, the first valid output appears 3 cycles after the next matrix_de.
